data_mem_responder: RTL and testbench

- Memory-side responder for the CPU's load/store port.
- Replaces the zero-latency data memory with a handshaked, multi-cycle memory; its wait time is set at build time.
- Accepts one word request at a time, stalls the requester for WAIT_CYCLES cycles, then returns read data or a store completion with an error flag.
- Lets a later multi-cycle or pipelined CPU be tested against realistic memory latency.

---
 rtl/data_mem_responder.sv | 85 ++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked word memory that answers WAIT_CYCLES wait states after accept; define DATA_MEM_ERR_CAPTURE_EN to add err_addr/err_sticky first-fault capture
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
`ifdef DATA_MEM_ERR_CAPTURE_EN
  ,
  output logic [31:0] err_addr,
  output logic        err_sticky
`endif
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q, wdata_q, c_addr, c_wdata;
  logic accept, commit, c_we, c_err;
  logic [AW-1:0] c_idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    accept = state == IDLE && req_valid;
    commit = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    c_we = state == IDLE ? req_we : we_q;
    c_addr = state == IDLE ? req_addr : addr_q;
    c_wdata = state == IDLE ? req_wdata : wdata_q;
    c_idx = c_addr[AW+1:2];
    c_err = c_addr[1:0] != 2'b00 || {2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS);
    state_nx = commit ? RESP : accept ? WAIT : (state == RESP && resp_ready) ? IDLE : state;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
`ifdef DATA_MEM_ERR_CAPTURE_EN
      err_addr <= '0;
      err_sticky <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (commit) begin
        resp_rdata <= (c_we || c_err) ? '0 : mem[c_idx];
        resp_err <= c_err;
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
`ifdef DATA_MEM_ERR_CAPTURE_EN
      if (commit && c_err && !err_sticky) begin
        err_addr <= c_addr;
        err_sticky <= 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk)
    if (commit && c_we && !c_err) mem[c_idx] <= c_wdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for two responders (WAIT_CYCLES 2 and 0)
module tb_data_mem_responder;
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req_valid [2], req_ready [2], req_we [2], resp_valid [2], resp_ready [2], resp_err [2], busy [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];
`ifdef DATA_MEM_ERR_CAPTURE_EN
  logic [31:0] err_addr [2];
  logic err_sticky [2];
`endif
  exp_t q [2][$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int probe_kind = 0;
  logic probe = 1'b0;
  logic done = 1'b0;
  int lat [2] = '{0, 0};
  int acc_cyc [2] = '{0, 0};
  int nacc [2] = '{0, 0};
  logic pend [2] = '{1'b0, 1'b0};
  logic pv [2] = '{1'b0, 1'b0};
  logic hs [2] = '{1'b0, 1'b0};
  logic perr [2] = '{1'b0, 1'b0};
  logic [31:0] prd [2] = '{32'h0, 32'h0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err(resp_err[g]),
      .busy(busy[g])
`ifdef DATA_MEM_ERR_CAPTURE_EN
      ,
      .err_addr(err_addr[g]),
      .err_sticky(err_sticky[g])
`endif
    );
  end
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction
  always @(negedge clk or posedge probe or posedge done) begin
    exp_t e;
    if (probe) begin
      for (int k = 0; k < 2; k++) begin
        if (probe_kind == 0) begin
          chk($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
          chk($sformatf("rst_resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
          chk($sformatf("rst_resp_rdata[%0d]", k), resp_rdata[k], 32'd0);
          chk($sformatf("rst_resp_err[%0d]", k), 32'(resp_err[k]), 32'd0);
          chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
`ifdef DATA_MEM_ERR_CAPTURE_EN
          chk($sformatf("rst_err_addr[%0d]", k), err_addr[k], 32'd0);
          chk($sformatf("rst_err_sticky[%0d]", k), 32'(err_sticky[k]), 32'd0);
`endif
        end
`ifdef DATA_MEM_ERR_CAPTURE_EN
        else if (k == 0) begin
          chk("err_addr", err_addr[0], 32'h12);
          chk("err_sticky", 32'(err_sticky[0]), 32'd1);
        end
`endif
      end
    end else if (done) begin
      for (int k = 0; k < 2; k++) chk($sformatf("leftover_expect[%0d]", k), 32'(q[k].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) begin
          pend[k] = 1'b0;
          pv[k] = 1'b0;
          hs[k] = 1'b0;
        end else begin
          lat[k]++;
          if (hs[k]) begin
            chk($sformatf("post_hs_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("post_hs_resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("post_hs_rdata[%0d]", k), resp_rdata[k], 32'd0);
            chk($sformatf("post_hs_err[%0d]", k), 32'(resp_err[k]), 32'd0);
          end
          if (resp_valid[k] && !pv[k]) begin
            if (q[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp[%0d]: got rdata %h with no expectation", k, resp_rdata[k]);
            end else begin
              e = q[k].pop_front();
              chk($sformatf("rdata[%0d]", k), resp_rdata[k], e.rdata);
              chk($sformatf("err[%0d]", k), 32'(resp_err[k]), 32'(e.err));
              chk($sformatf("latency[%0d]", k), 32'(lat[k]), k == 0 ? 32'd3 : 32'd1);
            end
            pend[k] = 1'b0;
          end else if (resp_valid[k]) begin
            chk($sformatf("hold_rdata[%0d]", k), resp_rdata[k], prd[k]);
            chk($sformatf("hold_err[%0d]", k), 32'(resp_err[k]), 32'(perr[k]));
            chk($sformatf("hold_req_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
          end
          if (pend[k] && lat[k] > 40) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout[%0d]: got no resp_valid want one within 40 cycles", k);
            pend[k] = 1'b0;
          end
          if (req_valid[k] && req_ready[k]) begin
            if (k == 1 && nacc[1] > 0) chk("b2b_accept_gap", 32'(cyc - acc_cyc[1]), 32'd2);
            acc_cyc[k] = cyc;
            nacc[k]++;
            lat[k] = 0;
            pend[k] = 1'b1;
          end
          hs[k] = resp_valid[k] && resp_ready[k];
          pv[k] = resp_valid[k];
          prd[k] = resp_rdata[k];
          perr[k] = resp_err[k];
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_probe(input int kind);
    probe_kind = kind;
    probe = 1'b1;
    #1 probe = 1'b0;
  endtask
  task automatic xact(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input int hold);
    int n;
    q[k].push_back('{rdata: er, err: ee});
    req_we[k] = we;
    req_addr[k] = a;
    req_wdata[k] = d;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin tick(); n++; end
    tick();
    req_valid[k] = 1'b0;
    n = 0;
    while (!resp_valid[k] && n < 50) begin tick(); n++; end
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid[k] = 1'b1;
        req_we[k] = 1'b0;
        req_addr[k] = 32'h10;
      end
      tick();
    end
    req_valid[k] = 1'b0;
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_we[k] = 1'b0;
      req_addr[k] = '0;
      req_wdata[k] = '0;
      resp_ready[k] = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1 pulse_probe(0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    xact(0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b1, 32'h12, 32'h55, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    xact(0, 1'b0, 32'h1001, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b1, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0, 0);
`ifdef DATA_MEM_ERR_CAPTURE_EN
    pulse_probe(1);
`endif
    xact(0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    req_we[0] = 1'b1;
    req_addr[0] = 32'h20;
    req_wdata[0] = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1 pulse_probe(0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    xact(0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 0);
    xact(1, 1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 0);
    xact(1, 1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h44, 32'h0, 32'h22222222, 1'b0, 0);
    xact(1, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 0);
    repeat (3) tick();
    done = 1'b1;
  end
endmodule
